// File: rtl/pulse_converter.sv
// Level-to-pulse converter: optional input synchronizer, selectable edge detect and retriggerable pulse stretcher.
// Optional feature macro: PULSE_CNT_EN adds the edge_count output and its counter.
`timescale 1ns/1ps
module pulse_converter #(
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned EDGE_SEL    = 0,
  parameter int unsigned PULSE_WIDTH = 1,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic                 out
`ifdef PULSE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] edge_count
`endif
);

  localparam int unsigned WCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  // Elaboration-time parameter legality checks
  if (PULSE_WIDTH == 0 || PULSE_WIDTH > 255) begin : g_bad_width
    $error("pulse_converter: PULSE_WIDTH must be 1..255");
  end
  if (EDGE_SEL > 2) begin : g_bad_edge
    $error("pulse_converter: EDGE_SEL must be 0..2");
  end
  if (SYNC_STAGES > 4) begin : g_bad_sync
    $error("pulse_converter: SYNC_STAGES must be 0..4");
  end
  if (CNT_WIDTH == 0) begin : g_bad_cnt
    $error("pulse_converter: CNT_WIDTH must be at least 1");
  end

  logic s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   chain;

    assign chain = {sync_q, in};
    assign s     = chain[SYNC_STAGES];

    // Reset preloads the live input so a level already high is not seen as an edge
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= {SYNC_STAGES{in}};
      end else begin
        sync_q <= chain[SYNC_STAGES-1:0];
      end
    end
  end

  logic           h_q;
  logic           out_q, out_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           rise, fall, det;

  // Edge select and retriggerable width counter
  always_comb begin
    rise   = s & ~h_q;
    fall   = ~s & h_q;
    det    = 1'b0;
    out_d  = 1'b0;
    wcnt_d = wcnt_q;
    case (EDGE_SEL)
      0:       det = rise;
      1:       det = fall;
      default: det = rise | fall;
    endcase
    if (det) begin
      out_d  = 1'b1;
      wcnt_d = WCW'(PULSE_WIDTH - 1);
    end else if (wcnt_q != '0) begin
      out_d  = 1'b1;
      wcnt_d = wcnt_q - WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= in;
      out_q  <= 1'b0;
      wcnt_q <= '0;
    end else begin
      h_q    <= s;
      out_q  <= out_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign out = out_q;

`ifdef PULSE_CNT_EN
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;

  // Counts every detected edge, retriggers included; wraps naturally
  always_comb begin
    ecnt_d = ecnt_q;
    if (det) begin
      ecnt_d = ecnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign edge_count = ecnt_q;
`endif

endmodule

// File: tb/tb_pulse_converter.sv
// Directed self-checking bench for pulse_converter across several parameter sets.
`timescale 1ns/1ps
module tb_pulse_converter;

  logic clk = 1'b0;
  logic reset;
  logic in0, in1, in2, in3, in4;
  logic out0, out1, out2, out3, out4;
  int   checks = 0;
  int   errors = 0;

`ifdef PULSE_CNT_EN
  logic [1:0] ec0;
  logic [7:0] ec1, ec2, ec3, ec4;
`endif

  always #5 clk = ~clk;

  // u0: defaults with a 2-bit edge counter
  pulse_converter #(.SYNC_STAGES(0), .EDGE_SEL(0), .PULSE_WIDTH(1), .CNT_WIDTH(2)) u0 (
    .clk(clk), .reset(reset), .in(in0), .out(out0)
`ifdef PULSE_CNT_EN
    , .edge_count(ec0)
`endif
  );
  // u1: both edges, single-cycle pulse
  pulse_converter #(.SYNC_STAGES(0), .EDGE_SEL(2), .PULSE_WIDTH(1), .CNT_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .in(in1), .out(out1)
`ifdef PULSE_CNT_EN
    , .edge_count(ec1)
`endif
  );
  // u2: 4-cycle pulse for retrigger and mid-pulse reset
  pulse_converter #(.SYNC_STAGES(0), .EDGE_SEL(0), .PULSE_WIDTH(4), .CNT_WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .in(in2), .out(out2)
`ifdef PULSE_CNT_EN
    , .edge_count(ec2)
`endif
  );
  // u3: two synchronizer stages
  pulse_converter #(.SYNC_STAGES(2), .EDGE_SEL(0), .PULSE_WIDTH(1), .CNT_WIDTH(8)) u3 (
    .clk(clk), .reset(reset), .in(in3), .out(out3)
`ifdef PULSE_CNT_EN
    , .edge_count(ec3)
`endif
  );
  // u4: falling edge, 2-cycle pulse
  pulse_converter #(.SYNC_STAGES(0), .EDGE_SEL(1), .PULSE_WIDTH(2), .CNT_WIDTH(8)) u4 (
    .clk(clk), .reset(reset), .in(in4), .out(out4)
`ifdef PULSE_CNT_EN
    , .edge_count(ec4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0] cseq [4];
    cseq[0] = 2'd2; cseq[1] = 2'd3; cseq[2] = 2'd0; cseq[3] = 2'd1;

    // Reset with inputs already high; u1 input held low
    reset = 1'b1;
    in0 = 1'b1; in1 = 1'b0; in2 = 1'b1; in3 = 1'b1; in4 = 1'b1;
    tick();
    tick();
    chk("reset_out0", {7'd0, out0}, 8'd0);
    chk("reset_out2", {7'd0, out2}, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out0", {7'd0, out0}, 8'd0);
      chk("hold_out1", {7'd0, out1}, 8'd0);
      chk("hold_out2", {7'd0, out2}, 8'd0);
      chk("hold_out3", {7'd0, out3}, 8'd0);
      chk("hold_out4", {7'd0, out4}, 8'd0);
    end
`ifdef PULSE_CNT_EN
    chk("reset_ec0", {6'd0, ec0}, 8'd0);
`endif

    // u0: falling edge gives nothing, rising edge gives one cycle
    in0 = 1'b0;
    tick(); chk("fall_out0_a", {7'd0, out0}, 8'd0);
    tick(); chk("fall_out0_b", {7'd0, out0}, 8'd0);
    in0 = 1'b1;
    tick(); chk("rise_out0_k1", {7'd0, out0}, 8'd1);
`ifdef PULSE_CNT_EN
    chk("rise_ec0_first", {6'd0, ec0}, 8'd1);
`endif
    tick(); chk("rise_out0_k2", {7'd0, out0}, 8'd0);
    tick(); chk("rise_out0_k3", {7'd0, out0}, 8'd0);

    // u0: four more rises, counter wraps at 2 bits
    for (int i = 0; i < 4; i++) begin
      in0 = 1'b0;
      tick();
      in0 = 1'b1;
      tick();
      chk("wrap_out0", {7'd0, out0}, 8'd1);
`ifdef PULSE_CNT_EN
      chk("wrap_ec0", {6'd0, ec0}, {6'd0, cseq[i]});
`endif
    end

    // Toggle train on u0 (rising) and u1 (both edges)
    in0 = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      in0 = ~in0;
      in1 = ~in1;
      tick();
      chk("train_out0", {7'd0, out0}, (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("train_out1", {7'd0, out1}, 8'd1);
    end
    tick();
    chk("train_end_out0", {7'd0, out0}, 8'd0);
    chk("train_end_out1", {7'd0, out1}, 8'd0);
`ifdef PULSE_CNT_EN
    chk("train_ec0", {6'd0, ec0}, 8'd2);
    chk("train_ec1", ec1, 8'd10);
`endif

    // u2: rise, then a second rise detected in the third pulse cycle -> 6 cycles high
    in2 = 1'b0;
    tick();
    tick();
    chk("pw4_idle", {7'd0, out2}, 8'd0);
    in2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) in2 = 1'b0;
      if (i == 1) in2 = 1'b1;
      chk("pw4_retrig", {7'd0, out2}, (i < 6) ? 8'd1 : 8'd0);
    end
`ifdef PULSE_CNT_EN
    chk("pw4_ec2", ec2, 8'd2);
`endif

    // u3: two sync stages -> pulse on third edge after the change
    in3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sync_fall_out3", {7'd0, out3}, 8'd0);
    end
    in3 = 1'b1;
    tick(); chk("sync_out3_k1", {7'd0, out3}, 8'd0);
    tick(); chk("sync_out3_k2", {7'd0, out3}, 8'd0);
    tick(); chk("sync_out3_k3", {7'd0, out3}, 8'd1);
    tick(); chk("sync_out3_k4", {7'd0, out3}, 8'd0);

    // u4: falling edge, 2-cycle pulse; rising edge ignored
    in4 = 1'b0;
    tick(); chk("fall_out4_k1", {7'd0, out4}, 8'd1);
    tick(); chk("fall_out4_k2", {7'd0, out4}, 8'd1);
    tick(); chk("fall_out4_k3", {7'd0, out4}, 8'd0);
    in4 = 1'b1;
    tick(); chk("fall_out4_rise_a", {7'd0, out4}, 8'd0);
    tick(); chk("fall_out4_rise_b", {7'd0, out4}, 8'd0);

    // Mid-pulse reset on u2; u0 edge coincident with reset is discarded
    in2 = 1'b0;
    tick();
    in2 = 1'b1;
    tick(); chk("mid_pre_a", {7'd0, out2}, 8'd1);
    tick(); chk("mid_pre_b", {7'd0, out2}, 8'd1);
    reset = 1'b1;
    in0 = 1'b1;
    tick();
    chk("mid_reset_out2", {7'd0, out2}, 8'd0);
    chk("mid_reset_out0", {7'd0, out0}, 8'd0);
    reset = 1'b0;
`ifdef PULSE_CNT_EN
    chk("mid_reset_ec0", {6'd0, ec0}, 8'd0);
    chk("mid_reset_ec2", ec2, 8'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_out2", {7'd0, out2}, 8'd0);
      chk("post_reset_out0", {7'd0, out0}, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
